// File: rtl/sniff_fifo_decoder_if.sv
// Valid/ready event bus plus the read port of a standard (non-FWFT) sniff FIFO.
// master = decoder side, slave = FIFO and event consumer side.
interface sniff_fifo_decoder_if #(
  parameter int pACC_WIDTH = 32
) ();
  logic                  O_fifo_rd_en;
  logic [17:0]           I_fifo_dout;
  logic                  I_fifo_empty;
  logic                  O_event_valid;
  logic                  I_event_ready;
  logic [pACC_WIDTH-1:0] O_event_time;
  logic [7:0]            O_event_data;
  logic [4:0]            O_event_stat;
  logic                  O_event_is_stat;

  modport master (
    output O_fifo_rd_en,
    input  I_fifo_dout,
    input  I_fifo_empty,
    output O_event_valid,
    input  I_event_ready,
    output O_event_time,
    output O_event_data,
    output O_event_stat,
    output O_event_is_stat
  );

  modport slave (
    input  O_fifo_rd_en,
    output I_fifo_dout,
    output I_fifo_empty,
    input  O_event_valid,
    output I_event_ready,
    input  O_event_time,
    input  O_event_data,
    input  O_event_stat,
    input  O_event_is_stat
  );
endinterface

// File: rtl/sniff_fifo_decoder.sv
// Decodes 18-bit sniff FIFO words into absolute-timestamped DATA/STAT events.
// TIME records only advance the accumulator; reserved commands are dropped and flagged.
module sniff_fifo_decoder #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pACC_WIDTH             = 32
) (
  input  logic                   cwusb_clk,
  input  logic                   reset_i,
  input  logic                   I_clear,
  sniff_fifo_decoder_if.master   bus,
  output logic [15:0]            O_event_count,
  output logic                   O_err_bad_cmd,
  output logic                   O_time_wrap
);

  localparam int SHORT_LSB = 2;
  localparam int DATA_LSB  = SHORT_LSB + pTIMESTAMP_SHORT_WIDTH;
  localparam int STAT_LSB  = DATA_LSB + 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_DATA = 2'd0,
    CMD_STAT = 2'd1,
    CMD_TIME = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_e;

  state_e                state_q, state_d;
  logic [pACC_WIDTH-1:0] acc_q, acc_d;
  logic                  valid_q, valid_d;
  logic [pACC_WIDTH-1:0] time_q, time_d;
  logic [7:0]            data_q, data_d;
  logic [4:0]            stat_q, stat_d;
  logic                  is_stat_q, is_stat_d;
  logic [15:0]           count_q, count_d;
  logic                  err_q, err_d;
  logic                  wrap_q, wrap_d;

  cmd_e                  cmd;
  logic [pACC_WIDTH-1:0] delta;
  logic [pACC_WIDTH:0]   sum;

  // Field extraction and the carry-extended accumulator sum are pure wiring.
  assign cmd   = cmd_e'(bus.I_fifo_dout[1:0]);
  assign delta = (cmd == CMD_TIME)
               ? pACC_WIDTH'(bus.I_fifo_dout[SHORT_LSB +: pTIMESTAMP_FULL_WIDTH])
               : pACC_WIDTH'(bus.I_fifo_dout[SHORT_LSB +: pTIMESTAMP_SHORT_WIDTH]);
  assign sum   = {1'b0, acc_q} + {1'b0, delta};

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    valid_d   = valid_q;
    time_d    = time_q;
    data_d    = data_q;
    stat_d    = stat_q;
    is_stat_d = is_stat_q;
    count_d   = count_q;
    err_d     = err_q;
    wrap_d    = wrap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.I_fifo_empty) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        unique case (cmd)
          CMD_TIME: begin
            acc_d = sum[pACC_WIDTH-1:0];
            if (sum[pACC_WIDTH]) wrap_d = 1'b1;
          end
          CMD_RSVD: begin
            err_d = 1'b1;
          end
          CMD_DATA, CMD_STAT: begin
            acc_d     = sum[pACC_WIDTH-1:0];
            if (sum[pACC_WIDTH]) wrap_d = 1'b1;
            time_d    = sum[pACC_WIDTH-1:0];
            data_d    = (cmd == CMD_STAT) ? 8'h00 : bus.I_fifo_dout[DATA_LSB +: 8];
            stat_d    = bus.I_fifo_dout[STAT_LSB +: 5];
            is_stat_d = (cmd == CMD_STAT);
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end
          default: ;
        endcase
      end

      ST_HOLD: begin
        if (bus.I_event_ready) begin
          valid_d = 1'b0;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = bus.I_fifo_empty ? ST_IDLE : ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Clear wins over everything, including a word already popped in FETCH/DECODE.
    if (I_clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      valid_d = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      time_q    <= '0;
      data_q    <= '0;
      stat_q    <= '0;
      is_stat_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      time_q    <= time_d;
      data_q    <= data_d;
      stat_q    <= stat_d;
      is_stat_q <= is_stat_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
    end
  end

  // Moore read strobe: FETCH is only entered with a non-empty FIFO.
  assign bus.O_fifo_rd_en    = (state_q == ST_FETCH);
  assign bus.O_event_valid   = valid_q;
  assign bus.O_event_time    = time_q;
  assign bus.O_event_data    = data_q;
  assign bus.O_event_stat    = stat_q;
  assign bus.O_event_is_stat = is_stat_q;
  assign O_event_count       = count_q;
  assign O_err_bad_cmd       = err_q;
  assign O_time_wrap         = wrap_q;

endmodule

// File: tb/tb_sniff_fifo_decoder.sv
// Bench for sniff_fifo_decoder: queue-based FIFO model, event monitor and an
// arithmetic reference model of the timestamp accumulator (16-bit build).
module tb_sniff_fifo_decoder;

  localparam int     ACC_W   = 16;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        clear;
  logic [15:0] count;
  logic        err;
  logic        wrap;

  sniff_fifo_decoder_if #(.pACC_WIDTH(ACC_W)) bus ();

  sniff_fifo_decoder #(
    .pTIMESTAMP_FULL_WIDTH (16),
    .pTIMESTAMP_SHORT_WIDTH(3),
    .pACC_WIDTH            (ACC_W)
  ) dut (
    .cwusb_clk    (clk),
    .reset_i      (reset_i),
    .I_clear      (clear),
    .bus          (bus.master),
    .O_event_count(count),
    .O_err_bad_cmd(err),
    .O_time_wrap  (wrap)
  );

  always #5 clk = ~clk;

  // Standard FIFO model: word appears on dout the cycle after a read strobe.
  logic [17:0] fifo_mem [0:2047];
  int          wr_ptr    = 0;
  int          rd_ptr    = 0;
  logic        underflow = 1'b0;

  assign bus.I_fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.O_fifo_rd_en) begin
      if (rd_ptr == wr_ptr) underflow <= 1'b1;
      else begin
        bus.I_fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr          <= rd_ptr + 1;
      end
    end
  end

  // Event monitor: records handshakes, watches output stability and rd_en while valid.
  logic [ACC_W-1:0] got_time [0:2047];
  logic [7:0]       got_data [0:2047];
  logic [4:0]       got_stat [0:2047];
  logic             got_is   [0:2047];
  int               got_cyc  [0:2047];
  int               got_n       = 0;
  int               cyc         = 0;
  logic             prev_valid  = 1'b0;
  logic [ACC_W+13:0] prev_bundle = '0;
  logic             unstable    = 1'b0;
  logic             rd_in_valid = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.O_event_valid) begin
      if (prev_valid && ({bus.O_event_time, bus.O_event_data, bus.O_event_stat,
                          bus.O_event_is_stat} !== prev_bundle))
        unstable <= 1'b1;
      if (bus.O_fifo_rd_en) rd_in_valid <= 1'b1;
      if (bus.I_event_ready) begin
        got_time[got_n] <= bus.O_event_time;
        got_data[got_n] <= bus.O_event_data;
        got_stat[got_n] <= bus.O_event_stat;
        got_is[got_n]   <= bus.O_event_is_stat;
        got_cyc[got_n]  <= cyc;
        got_n           <= got_n + 1;
      end
    end
    prev_valid  <= bus.O_event_valid;
    prev_bundle <= {bus.O_event_time, bus.O_event_data, bus.O_event_stat, bus.O_event_is_stat};
  end

  // Reference model state and expected event list.
  longint m_acc  = 0;
  bit     m_err  = 1'b0;
  bit     m_wrap = 1'b0;
  longint exp_time [0:2047];
  int     exp_data [0:2047];
  int     exp_stat [0:2047];
  int     exp_is   [0:2047];
  int     exp_n    = 0;
  int     cnt_base = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task model_apply(input logic [17:0] w);
    int     wi;
    longint sum;
    wi = int'(w);
    case (wi & 3)
      2: begin
        sum = m_acc + longint'((wi >> 2) & 16'hFFFF);
        if (sum >= ACC_MOD) begin m_wrap = 1'b1; sum = sum - ACC_MOD; end
        m_acc = sum;
      end
      3: m_err = 1'b1;
      default: begin
        sum = m_acc + longint'((wi >> 2) & 7);
        if (sum >= ACC_MOD) begin m_wrap = 1'b1; sum = sum - ACC_MOD; end
        m_acc           = sum;
        exp_time[exp_n] = sum;
        exp_is[exp_n]   = wi & 1;
        exp_data[exp_n] = ((wi & 3) == 1) ? 0 : ((wi >> 5) & 255);
        exp_stat[exp_n] = (wi >> 13) & 31;
        exp_n++;
      end
    endcase
  endtask

  task push(input logic [17:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
    model_apply(w);
  endtask

  function automatic logic [17:0] rand_word(input bit events_only);
    logic [17:0] w;
    int          r;
    w = 18'($urandom);
    r = events_only ? $urandom_range(0, 6) : $urandom_range(0, 9);
    if (r <= 3)      w[1:0] = 2'd0;
    else if (r <= 6) w[1:0] = 2'd1;
    else if (r <= 8) w[1:0] = 2'd2;
    else             w[1:0] = 2'd3;
    return w;
  endfunction

  task wait_drain(input string tag, input int budget, input bit rnd_ready);
    int k;
    k = 0;
    while (!(got_n == exp_n && rd_ptr == wr_ptr && !bus.O_event_valid) && k < budget) begin
      if (rnd_ready) bus.I_event_ready = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    bus.I_event_ready = 1'b1;
    repeat (3) tick();
    check({tag, "_drain_in_budget"}, 64'(k < budget), 64'd1);
  endtask

  task compare_events(input string tag, input int from);
    for (int i = from; i < exp_n; i++) begin
      check($sformatf("%s_time[%0d]", tag, i), 64'(got_time[i]), 64'(exp_time[i]));
      check($sformatf("%s_data[%0d]", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      check($sformatf("%s_stat[%0d]", tag, i), 64'(got_stat[i]), 64'(exp_stat[i]));
      check($sformatf("%s_is[%0d]", tag, i),   64'(got_is[i]),   64'(exp_is[i]));
    end
  endtask

  task do_clear();
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    m_acc    = 0;
    m_err    = 1'b0;
    m_wrap   = 1'b0;
    exp_n    = got_n;
    cnt_base = got_n;
  endtask

  initial begin
    int lat;
    int base;
    int rd_base;

    reset_i           = 1'b1;
    clear             = 1'b0;
    bus.I_event_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid",   64'(bus.O_event_valid),   64'd0);
    check("rst_rd_en",   64'(bus.O_fifo_rd_en),    64'd0);
    check("rst_time",    64'(bus.O_event_time),    64'd0);
    check("rst_data",    64'(bus.O_event_data),    64'd0);
    check("rst_stat",    64'(bus.O_event_stat),    64'd0);
    check("rst_is_stat", 64'(bus.O_event_is_stat), 64'd0);
    check("rst_count",   64'(count),               64'd0);
    check("rst_err",     64'(err),                 64'd0);
    check("rst_wrap",    64'(wrap),                64'd0);
    reset_i = 1'b0;
    tick();

    // Single DATA event, plus read-to-valid latency.
    bus.I_event_ready = 1'b1;
    push(18'h234B4);
    lat = 0;
    while (!bus.O_event_valid && lat < 20) begin tick(); lat++; end
    check("c1_latency", 64'(lat), 64'd3);
    wait_drain("c1", 50, 1'b0);
    check("c1_n",     64'(got_n),       64'd1);
    check("c1_time",  64'(got_time[0]), 64'd5);
    check("c1_data",  64'(got_data[0]), 64'hA5);
    check("c1_stat",  64'(got_stat[0]), 64'h11);
    check("c1_is",    64'(got_is[0]),   64'd0);
    check("c1_count", 64'(count),       64'd1);
    check("c1_reads", 64'(rd_ptr),      64'd1);

    // TIME then DATA: one event at 5 + 0x1234 + 3.
    push(18'h048D2);
    push(18'h0000C);
    wait_drain("c2", 60, 1'b0);
    check("c2_n",    64'(got_n),       64'd2);
    check("c2_time", 64'(got_time[1]), 64'h123C);

    // STAT record: data forced to 0.
    push(18'h3E005);
    wait_drain("c3", 50, 1'b0);
    check("c3_time", 64'(got_time[2]), 64'h123D);
    check("c3_data", 64'(got_data[2]), 64'd0);
    check("c3_stat", 64'(got_stat[2]), 64'h1F);
    check("c3_is",   64'(got_is[2]),   64'd1);

    // Reserved command dropped, then DATA delta 2.
    push(18'h0000F);
    push(18'h00008);
    wait_drain("c4", 60, 1'b0);
    check("c4_err",  64'(err),         64'd1);
    check("c4_n",    64'(got_n),       64'd4);
    check("c4_time", 64'(got_time[3]), 64'h123F);
    compare_events("c1to4", 0);

    // Back-pressure with 4 queued events, then drain at full rate.
    do_clear();
    check("c5_clr_count", 64'(count), 64'd0);
    check("c5_clr_err",   64'(err),   64'd0);
    bus.I_event_ready = 1'b0;
    base    = got_n;
    rd_base = rd_ptr;
    for (int i = 0; i < 4; i++) push(rand_word(1'b1));
    repeat (10) tick();
    check("c5_valid_held", 64'(bus.O_event_valid), 64'd1);
    check("c5_no_accept",  64'(got_n - base),      64'd0);
    check("c5_one_read",   64'(rd_ptr - rd_base),  64'd1);
    bus.I_event_ready = 1'b1;
    wait_drain("c5", 60, 1'b0);
    check("c5_count", 64'(count), 64'd4);
    compare_events("c5", base);
    for (int i = 1; i < 4; i++)
      check($sformatf("c5_spacing[%0d]", i), 64'(got_cyc[base+i] - got_cyc[base+i-1]), 64'd3);

    // Randomized mix with random back-pressure against the reference model.
    do_clear();
    base = got_n;
    for (int i = 0; i < 150; i++) push(rand_word(1'b0));
    wait_drain("rnd", 3000, 1'b1);
    compare_events("rnd", base);
    check("rnd_count", 64'(count), 64'(got_n - cnt_base));
    check("rnd_err",   64'(err),   64'(m_err));
    check("rnd_wrap",  64'(wrap),  64'(m_wrap));

    // Accumulator wrap, then clear in the middle of HOLD.
    do_clear();
    push({16'hFFFC, 2'b10});
    push(18'h0001C);
    wait_drain("wrap", 60, 1'b0);
    check("wrap_time", 64'(got_time[got_n-1]), 64'd3);
    check("wrap_flag", 64'(wrap),              64'd1);
    bus.I_event_ready = 1'b0;
    push(18'h00010);
    lat = 0;
    while (!bus.O_event_valid && lat < 20) begin tick(); lat++; end
    check("hold_reached", 64'(bus.O_event_valid), 64'd1);
    tick();
    do_clear();
    check("clr_valid", 64'(bus.O_event_valid), 64'd0);
    check("clr_count", 64'(count),             64'd0);
    check("clr_err",   64'(err),               64'd0);
    check("clr_wrap",  64'(wrap),              64'd0);
    bus.I_event_ready = 1'b1;
    push(18'h00008);
    wait_drain("post_clr", 60, 1'b0);
    check("post_clr_time",  64'(got_time[got_n-1]), 64'd2);
    check("post_clr_count", 64'(count),             64'd1);

    check("stable_while_valid", 64'(unstable),    64'd0);
    check("no_rd_while_valid",  64'(rd_in_valid), 64'd0);
    check("no_underflow",       64'(underflow),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
